// File: rtl/matrix_if_pkg.sv
// matrix_if_pkg
//   Shared definitions for the 8x8 LED-matrix link receiver.
//   - MATRIX_COLS / MATRIX_ROWS : panel geometry
//   - SHIFT_BITS_DEF            : bits per column word {red_row, blue_row}
//   - frame_t                   : one colour plane, indexed [col][row]
//   - cap_phase_t               : capture FSM phase
//   - is_onehot8()              : column-select validity test
package matrix_if_pkg;

    localparam int MATRIX_COLS    = 8;
    localparam int MATRIX_ROWS    = 8;
    localparam int SHIFT_BITS_DEF = 16;

    typedef logic [MATRIX_COLS-1:0][MATRIX_ROWS-1:0] frame_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFTING = 2'd1,
        LATCH    = 2'd2
    } cap_phase_t;

    function automatic logic is_onehot8(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

endpackage

// File: rtl/matrix_frame_capture_sync.sv
// link_edge_sync
//   Brings a group of link lines onto clk: SYNC_STAGES synchronizer flops,
//   then one edge register holding the current and previous sample.
//   Data lines use the same module purely as a matched delay line so they
//   stay aligned with the edges detected on the control lines.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   din        : raw link lines
//   level      : synchronized level (edge-register output)
//   rise       : one-cycle rising-edge strobe, level & ~previous
module link_edge_sync #(
    parameter int               WIDTH       = 1,
    parameter int               SYNC_STAGES = 0,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] prev;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [WIDTH-1:0] stage [SYNC_STAGES];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        stage[i] <= RESET_VAL;
                    end
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign sync_out = stage[SYNC_STAGES-1];
        end else begin : g_nosync
            assign sync_out = din;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur  <= RESET_VAL;
            prev <= RESET_VAL;
        end else begin
            cur  <= sync_out;
            prev <= cur;
        end
    end

    assign level = cur;
    assign rise  = cur & ~prev;

endmodule

// File: rtl/matrix_frame_capture.sv
// matrix_frame_capture
//   Receiving end of the 8x8 LED-matrix shift-register link. Rebuilds the
//   red/blue image from the DS / SH_CP / ST_CP stream: one 16-bit column
//   word {red_row, blue_row} is latched per store pulse into the column
//   selected by col_select, and a pulse is raised when all 8 columns have
//   been stored since the previous pulse.
// Ports:
//   clk, reset           : system clock, asynchronous active-high reset
//   sr_reset_n           : link shift-register master reset, active low
//   oe_n                 : link output enable, active low
//   sh_cp, st_cp, ds     : link shift clock, store clock, serial data
//   col_select[7:0]      : active column, one-hot
//   frame_red/frame_blue : captured image planes, [col][row]
//   frame_valid          : one-cycle pulse per completed frame
//   col_mask[7:0]        : columns stored in the current frame
//   err_len, err_col     : sticky store errors (bit count, column select)
//   blank                : registered oe_n
//   phase                : capture FSM state, for observation
module matrix_frame_capture
    import matrix_if_pkg::*;
#(
    parameter int SHIFT_BITS  = SHIFT_BITS_DEF,
    parameter int SYNC_STAGES = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sr_reset_n,
    input  logic       oe_n,
    input  logic       sh_cp,
    input  logic       st_cp,
    input  logic       ds,
    input  logic [7:0] col_select,
    output frame_t     frame_red,
    output frame_t     frame_blue,
    output logic       frame_valid,
    output logic [7:0] col_mask,
    output logic       err_len,
    output logic       err_col,
    output logic       blank,
    output cap_phase_t phase
);

    localparam logic [4:0] BITCNT_MAX  = 5'd31;
    localparam logic [4:0] BITCNT_FULL = 5'(SHIFT_BITS);

    // ---------------------------------------------------------------
    // Link input conditioning; every line sees the same latency.
    // ---------------------------------------------------------------
    logic       sh_lvl, sh_rise;
    logic       st_lvl, st_rise;
    logic       srr_lvl, srr_rise;
    logic       oe_lvl, oe_rise;
    logic       ds_lvl, ds_rise;
    logic [7:0] col_lvl, col_rise;

    link_edge_sync #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sh (
        .clk(clk), .reset(reset), .din(sh_cp), .level(sh_lvl), .rise(sh_rise));
    link_edge_sync #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_st (
        .clk(clk), .reset(reset), .din(st_cp), .level(st_lvl), .rise(st_rise));
    // Idle-high lines reset high so no spurious clear/unblank follows reset.
    link_edge_sync #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_srr (
        .clk(clk), .reset(reset), .din(sr_reset_n), .level(srr_lvl), .rise(srr_rise));
    link_edge_sync #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_oe (
        .clk(clk), .reset(reset), .din(oe_n), .level(oe_lvl), .rise(oe_rise));
    link_edge_sync #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_ds (
        .clk(clk), .reset(reset), .din(ds), .level(ds_lvl), .rise(ds_rise));
    link_edge_sync #(.WIDTH(8), .SYNC_STAGES(SYNC_STAGES), .RESET_VAL(8'h00)) u_col (
        .clk(clk), .reset(reset), .din(col_select), .level(col_lvl), .rise(col_rise));

    // Only levels are needed from these lines; their edge strobes are spare.
    logic unused_link;
    assign unused_link = ^{sh_lvl, st_lvl, srr_rise, oe_rise, ds_rise, col_rise};

    // ---------------------------------------------------------------
    // Shift register and bit counter
    // ---------------------------------------------------------------
    logic [SHIFT_BITS-1:0] shreg;
    logic [4:0]            bitcnt;

    // A store coinciding with a shift latches the pre-shift word (74HC595
    // behaviour); the shifted bit then becomes bit 1 of the next word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg  <= '0;
            bitcnt <= '0;
        end else if (!srr_lvl) begin
            shreg  <= '0;
            bitcnt <= '0;
        end else if (sh_rise) begin
            shreg <= {shreg[SHIFT_BITS-2:0], ds_lvl};
            if (st_rise) begin
                bitcnt <= 5'd1;
            end else if (bitcnt != BITCNT_MAX) begin
                bitcnt <= bitcnt + 5'd1;
            end
        end else if (st_rise) begin
            bitcnt <= '0;
        end
    end

    // ---------------------------------------------------------------
    // Latch into frame buffer, frame completion, error flags, blank
    // ---------------------------------------------------------------
    logic       col_ok;
    logic [7:0] mask_next;

    assign col_ok    = is_onehot8(col_lvl);
    assign mask_next = col_mask | col_lvl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_red   <= '0;
            frame_blue  <= '0;
            frame_valid <= 1'b0;
            col_mask    <= 8'h00;
            err_len     <= 1'b0;
            err_col     <= 1'b0;
            blank       <= 1'b1;
        end else begin
            frame_valid <= 1'b0;
            blank       <= oe_lvl;
            if (st_rise) begin
                if (bitcnt != BITCNT_FULL) begin
                    err_len <= 1'b1;
                end
                if (!col_ok) begin
                    err_col <= 1'b1;
                end else begin
                    for (int k = 0; k < MATRIX_COLS; k++) begin
                        if (col_lvl[k]) begin
                            frame_red[k]  <= shreg[2*MATRIX_ROWS-1:MATRIX_ROWS];
                            frame_blue[k] <= shreg[MATRIX_ROWS-1:0];
                        end
                    end
                    // Completion clears the mask in the same cycle, so the
                    // next store always opens a fresh frame.
                    if (mask_next == 8'hFF) begin
                        frame_valid <= 1'b1;
                        col_mask    <= 8'h00;
                    end else begin
                        col_mask <= mask_next;
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Capture phase FSM (observational; does not gate the datapath)
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= IDLE;
        end else if (st_rise) begin
            phase <= LATCH;
        end else if (!srr_lvl) begin
            phase <= IDLE;
        end else begin
            case (phase)
                IDLE:     if (sh_rise) phase <= SHIFTING;
                SHIFTING: phase <= SHIFTING;
                LATCH:    phase <= sh_rise ? SHIFTING : IDLE;
                default:  phase <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_frame_capture.sv
// tb_matrix_frame_capture
//   Drives the same link stream into two receivers, one with no
//   synchronizer (dut0) and one with two synchronizer stages (dut2), and
//   compares both against hand-computed column words held in a table.
module tb_matrix_frame_capture;
    import matrix_if_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       sr_reset_n, oe_n, sh_cp, st_cp, ds;
    logic [7:0] col_select;

    frame_t     red0, blue0, red2, blue2;
    logic       fv0, fv2, el0, el2, ec0, ec2, bl0, bl2;
    logic [7:0] mask0, mask2;
    cap_phase_t ph0, ph2;

    matrix_frame_capture #(.SHIFT_BITS(16), .SYNC_STAGES(0)) dut0 (
        .clk(clk), .reset(rst), .sr_reset_n(sr_reset_n), .oe_n(oe_n),
        .sh_cp(sh_cp), .st_cp(st_cp), .ds(ds), .col_select(col_select),
        .frame_red(red0), .frame_blue(blue0), .frame_valid(fv0),
        .col_mask(mask0), .err_len(el0), .err_col(ec0), .blank(bl0),
        .phase(ph0));

    matrix_frame_capture #(.SHIFT_BITS(16), .SYNC_STAGES(2)) dut2 (
        .clk(clk), .reset(rst), .sr_reset_n(sr_reset_n), .oe_n(oe_n),
        .sh_cp(sh_cp), .st_cp(st_cp), .ds(ds), .col_select(col_select),
        .frame_red(red2), .frame_blue(blue2), .frame_valid(fv2),
        .col_mask(mask2), .err_len(el2), .err_col(ec2), .blank(bl2),
        .phase(ph2));

    localparam int HOLD = 3;

    int n_checks = 0;
    int n_errors = 0;

    // frame_valid high-cycle counters; a stretched pulse shows up as extra counts
    int fv_cnt0 = 0;
    int fv_cnt2 = 0;
    always @(negedge clk) begin
        if (rst) begin
            fv_cnt0 = 0;
            fv_cnt2 = 0;
        end else begin
            if (fv0) fv_cnt0++;
            if (fv2) fv_cnt2++;
        end
    end

    // ---------------- expected-state model ----------------
    frame_t     exp_red, exp_blue;
    logic [7:0] exp_mask;
    logic       exp_el, exp_ec;
    int         exp_frames;

    typedef struct {
        logic [7:0]  col;
        logic [31:0] data;
        int          nbits;
        int          wr_col;   // -1: no column written
        logic [15:0] word;     // shift-register contents at the store
        logic [7:0]  mask;
        logic        el;
        logic        ec;
        int          frames;
    } vec_t;

    vec_t vecs [16];

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    task automatic check_all(input string tag);
        check($sformatf("%s dut0 red", tag), red0, exp_red);
        check($sformatf("%s dut0 blue", tag), blue0, exp_blue);
        check($sformatf("%s dut0 col_mask", tag), {56'd0, mask0}, {56'd0, exp_mask});
        check($sformatf("%s dut0 err_len", tag), {63'd0, el0}, {63'd0, exp_el});
        check($sformatf("%s dut0 err_col", tag), {63'd0, ec0}, {63'd0, exp_ec});
        check($sformatf("%s dut0 frames", tag), 64'(fv_cnt0), 64'(exp_frames));
        check($sformatf("%s dut2 red", tag), red2, exp_red);
        check($sformatf("%s dut2 blue", tag), blue2, exp_blue);
        check($sformatf("%s dut2 col_mask", tag), {56'd0, mask2}, {56'd0, exp_mask});
        check($sformatf("%s dut2 err_len", tag), {63'd0, el2}, {63'd0, exp_el});
        check($sformatf("%s dut2 err_col", tag), {63'd0, ec2}, {63'd0, exp_ec});
        check($sformatf("%s dut2 frames", tag), 64'(fv_cnt2), 64'(exp_frames));
    endtask

    task automatic model_reset();
        exp_red    = '0;
        exp_blue   = '0;
        exp_mask   = 8'h00;
        exp_el     = 1'b0;
        exp_ec     = 1'b0;
        exp_frames = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        sh_cp = 1'b0;
        st_cp = 1'b0;
        cycles(3);
        rst = 1'b0;
        cycles(2);
        model_reset();
    endtask

    task automatic shift_bit(input logic b);
        ds    = b;
        sh_cp = 1'b0;
        cycles(HOLD);
        sh_cp = 1'b1;
        cycles(HOLD);
    endtask

    // MSB first, so bit 0 of the value ends up as blue row 0.
    task automatic shift_word(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) shift_bit(v[i]);
    endtask

    task automatic store(input logic [7:0] col);
        col_select = col;
        st_cp      = 1'b0;
        cycles(HOLD);
        st_cp = 1'b1;
        cycles(HOLD);
        st_cp = 1'b0;
        cycles(6);
    endtask

    task automatic apply_vec(input int i);
        shift_word(vecs[i].data, vecs[i].nbits);
        store(vecs[i].col);
        if (vecs[i].wr_col >= 0) begin
            exp_red[vecs[i].wr_col]  = vecs[i].word[15:8];
            exp_blue[vecs[i].wr_col] = vecs[i].word[7:0];
        end
        exp_mask   = vecs[i].mask;
        exp_el     = vecs[i].el;
        exp_ec     = vecs[i].ec;
        exp_frames = vecs[i].frames;
        check_all($sformatf("vec%0d", i));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    // ---------------- test ----------------
    initial begin
        // col, data, nbits, wr_col, word, mask, err_len, err_col, frames
        vecs[0]  = '{8'h04, 32'h0000A53C, 16,  2, 16'hA53C, 8'h04, 1'b0, 1'b0, 0};
        vecs[1]  = '{8'h01, 32'h00000000, 16,  0, 16'h0000, 8'h05, 1'b0, 1'b0, 0};
        vecs[2]  = '{8'h02, 32'h00001100, 16,  1, 16'h1100, 8'h07, 1'b0, 1'b0, 0};
        vecs[3]  = '{8'h04, 32'h00002200, 16,  2, 16'h2200, 8'h07, 1'b0, 1'b0, 0};
        vecs[4]  = '{8'h08, 32'h00003300, 16,  3, 16'h3300, 8'h0F, 1'b0, 1'b0, 0};
        vecs[5]  = '{8'h10, 32'h00004400, 16,  4, 16'h4400, 8'h1F, 1'b0, 1'b0, 0};
        vecs[6]  = '{8'h20, 32'h00005500, 16,  5, 16'h5500, 8'h3F, 1'b0, 1'b0, 0};
        vecs[7]  = '{8'h40, 32'h00006600, 16,  6, 16'h6600, 8'h7F, 1'b0, 1'b0, 0};
        vecs[8]  = '{8'h80, 32'h00007700, 16,  7, 16'h7700, 8'h00, 1'b0, 1'b0, 1};
        // run after the same-edge and sr_reset_n sequences (shreg = 0x0F0F)
        vecs[9]  = '{8'h02, 32'h00001234, 15,  1, 16'h9234, 8'h9A, 1'b1, 1'b0, 1};
        vecs[10] = '{8'h06, 32'h0000BEEF, 16, -1, 16'h0000, 8'h9A, 1'b1, 1'b1, 1};
        vecs[11] = '{8'h00, 32'h00005555, 16, -1, 16'h0000, 8'h9A, 1'b1, 1'b1, 1};
        vecs[12] = '{8'h01, 32'h0001C3D2, 17,  0, 16'hC3D2, 8'h9B, 1'b1, 1'b1, 1};
        vecs[13] = '{8'h04, 32'h00002468, 16,  2, 16'h2468, 8'h9F, 1'b1, 1'b1, 1};
        vecs[14] = '{8'h20, 32'h00005A5A, 16,  5, 16'h5A5A, 8'hBF, 1'b1, 1'b1, 1};
        vecs[15] = '{8'h40, 32'h00006B6B, 16,  6, 16'h6B6B, 8'h00, 1'b1, 1'b1, 2};

        rst        = 1'b1;
        sr_reset_n = 1'b1;
        oe_n       = 1'b1;
        sh_cp      = 1'b0;
        st_cp      = 1'b0;
        ds         = 1'b0;
        col_select = 8'h00;
        model_reset();
        cycles(3);

        // reset values, sampled while reset is held
        check_all("reset");
        check("reset dut0 frame_valid", {63'd0, fv0}, 64'd0);
        check("reset dut2 frame_valid", {63'd0, fv2}, 64'd0);
        check("reset dut0 blank", {63'd0, bl0}, 64'd1);
        check("reset dut2 blank", {63'd0, bl2}, 64'd1);
        check("reset dut0 phase", {62'd0, ph0}, {62'd0, IDLE});
        check("reset dut2 phase", {62'd0, ph2}, {62'd0, IDLE});
        rst = 1'b0;
        cycles(2);

        // blank latency: 2 edges without sync, 4 edges with two sync stages
        oe_n = 1'b0;
        @(posedge clk); #2;
        check("blank dut0 edge1", {63'd0, bl0}, 64'd1);
        check("blank dut2 edge1", {63'd0, bl2}, 64'd1);
        @(posedge clk); #2;
        check("blank dut0 edge2", {63'd0, bl0}, 64'd0);
        check("blank dut2 edge2", {63'd0, bl2}, 64'd1);
        @(posedge clk); #2;
        check("blank dut2 edge3", {63'd0, bl2}, 64'd1);
        @(posedge clk); #2;
        check("blank dut2 edge4", {63'd0, bl2}, 64'd0);
        cycles(1);

        // single column, then a full frame with a rewritten column
        for (int i = 0; i <= 8; i++) apply_vec(i);

        // shift and store rising together: pre-shift word latched
        shift_word(32'h0000FFFF, 16);
        col_select = 8'h08;
        ds         = 1'b0;
        sh_cp      = 1'b0;
        st_cp      = 1'b0;
        cycles(HOLD);
        sh_cp = 1'b1;
        st_cp = 1'b1;
        cycles(HOLD);
        st_cp = 1'b0;
        cycles(6);
        exp_red[3]  = 8'hFF;
        exp_blue[3] = 8'hFF;
        exp_mask    = 8'h08;
        check_all("same_edge");

        // the bit shifted on the shared edge counts, so 15 more make a full word
        shift_word(32'h00001357, 15);
        store(8'h10);
        exp_red[4]  = 8'h13;
        exp_blue[4] = 8'h57;
        exp_mask    = 8'h18;
        check_all("bitcnt_one");

        // sr_reset_n discards a partial word but not the stored frame
        shift_word(32'h000000AB, 8);
        sr_reset_n = 1'b0;
        cycles(3);
        sr_reset_n = 1'b1;
        cycles(3);
        shift_word(32'h00000F0F, 16);
        store(8'h80);
        exp_red[7]  = 8'h0F;
        exp_blue[7] = 8'h0F;
        exp_mask    = 8'h98;
        check_all("sr_clear");

        // length / column errors, over-length word, frame completion
        for (int i = 9; i <= 15; i++) apply_vec(i);

        // reset clears sticky errors; then reset mid-frame and mid-word
        do_reset();
        check_all("reset2");
        for (int k = 0; k < 5; k++) begin
            logic [15:0] w;
            logic [7:0]  c;
            w = {8'(8'h30 + k), 8'(8'hC0 - k)};
            c = 8'(1 << k);
            shift_word({16'd0, w}, 16);
            store(c);
            exp_red[k]  = w[15:8];
            exp_blue[k] = w[7:0];
            exp_mask    = exp_mask | c;
            check_all($sformatf("pre_reset col%0d", k));
        end
        shift_word(32'h000000AB, 8);
        #2;
        rst = 1'b1;
        #1;
        check("async dut0 col_mask", {56'd0, mask0}, 64'd0);
        check("async dut2 col_mask", {56'd0, mask2}, 64'd0);
        check("async dut0 red", red0, 64'd0);
        check("async dut2 red", red2, 64'd0);
        sh_cp = 1'b0;
        cycles(3);
        rst = 1'b0;
        cycles(2);
        model_reset();
        check_all("mid_reset");

        for (int k = 0; k < 8; k++) begin
            logic [15:0] w;
            logic [7:0]  c;
            w = {8'(8'h30 + k), 8'(8'hC0 - k)};
            c = 8'(1 << k);
            shift_word({16'd0, w}, 16);
            store(c);
            exp_red[k]  = w[15:8];
            exp_blue[k] = w[7:0];
            if (k == 7) begin
                exp_mask   = 8'h00;
                exp_frames = 1;
            end else begin
                exp_mask = exp_mask | c;
            end
            check_all($sformatf("post_reset col%0d", k));
        end

        // store with no bits shifted: still latches the kept word, flags length
        store(8'h01);
        exp_red[0]  = 8'h37;
        exp_blue[0] = 8'hB9;
        exp_mask    = 8'h01;
        exp_el      = 1'b1;
        check_all("idle_store");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
